// File: rtl/memmu_sr_scheduler.sv
// Two-requester round-robin front end for the spherical-representation mapper:
// clamps an angle in centidegrees and converts it to an address and correction.
module memmu_sr_scheduler #(
    parameter int NUMBER_OF_ADDR_BITS = 11,
    parameter int FOV                 = 360
) (
    input  logic                           i_SYSTEM_clk,
    input  logic                           i_SYSTEM_rst,
    input  logic                           i_req0_valid,
    input  logic                           i_req1_valid,
    input  logic [15:0]                    i_req0_angle,
    input  logic [15:0]                    i_req1_angle,
    output logic                           o_req0_ready,
    output logic                           o_req1_ready,
    input  logic                           i_flush,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [NUMBER_OF_ADDR_BITS-1:0] o_address,
    output logic [3:0]                     o_correction,
    output logic                           o_id,
    output logic                           o_clamped,
    output logic [15:0]                    o_count0,
    output logic [15:0]                    o_count1
);

    localparam int AW     = NUMBER_OF_ADDR_BITS;
    localparam int N      = 2 ** NUMBER_OF_ADDR_BITS;
    localparam int RES    = (FOV * 100) / N + 1;
    localparam int MAXFOV = FOV * 100 - 1;
    localparam int FACTOR = N / RES;

    localparam logic [15:0] MAXFOV_C = 16'(MAXFOV);
    localparam logic [31:0] FACTOR_C = 32'(FACTOR);
    localparam logic [31:0] RES_C    = 32'(RES);

    function automatic logic [15:0] clamp_angle(input logic [15:0] angle);
        logic [15:0] res;
        if (angle >= MAXFOV_C) begin
            res = MAXFOV_C;
        end else begin
            res = angle;
        end
        return res;
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [31:0] product);
        return AW'(product >> AW);
    endfunction

    // Residual of the angle not covered by the address grid, kept to 4 bits.
    function automatic logic [3:0] correction_of(input logic [15:0] angle, input logic [AW-1:0] addr);
        return 4'({16'd0, angle} - (32'(addr) * RES_C));
    endfunction

    logic          s1_valid_q;
    logic          s1_id_q;
    logic          s1_clamped_q;
    logic [15:0]   s1_angle_q;
    logic [31:0]   s1_product_q;
    logic          o_valid_q;
    logic [AW-1:0] o_address_q;
    logic [3:0]    o_correction_q;
    logic          o_id_q;
    logic          o_clamped_q;
    logic [15:0]   count0_q;
    logic [15:0]   count1_q;
    logic          prio_q;
    logic          prio_d;
    logic [15:0]   count0_d;
    logic [15:0]   count1_d;

    logic          adv1_s;
    logic          adv2_s;
    logic          gnt0_s;
    logic          gnt1_s;
    logic [15:0]   sel_angle_s;
    logic [15:0]   clamped_angle_s;
    logic          sel_clamped_s;
    logic [31:0]   product_s;
    logic [AW-1:0] s1_addr_s;

    // Pipeline advance conditions.
    always_comb begin
        adv2_s = !o_valid_q || i_ready;
        adv1_s = !s1_valid_q || adv2_s;
    end

    // Round-robin grant; prio_q=0 favours requester 0, nothing accepted while flushing.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (adv1_s && !i_flush) begin
            if (i_req0_valid && i_req1_valid) begin
                gnt0_s = !prio_q;
                gnt1_s = prio_q;
            end else begin
                gnt0_s = i_req0_valid;
                gnt1_s = i_req1_valid;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Selected angle, clamp flag and scaled product for stage 1.
    always_comb begin
        if (gnt1_s) begin
            sel_angle_s = i_req1_angle;
        end else begin
            sel_angle_s = i_req0_angle;
        end
        clamped_angle_s = clamp_angle(sel_angle_s);
        sel_clamped_s   = (sel_angle_s >= MAXFOV_C);
        product_s       = {16'd0, clamped_angle_s} * FACTOR_C;
    end

    // Next priority and counter values.
    always_comb begin
        prio_d   = prio_q;
        count0_d = count0_q;
        count1_d = count1_q;
        if (gnt0_s) begin
            prio_d   = 1'b1;
            count0_d = count0_q + 16'd1;
        end else if (gnt1_s) begin
            prio_d   = 1'b0;
            count1_d = count1_q + 16'd1;
        end else begin
            prio_d   = prio_q;
        end
    end

    assign s1_addr_s = addr_of(s1_product_q);

    // Stage 1: arbitration result, clamp and product.
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_clamped_q <= 1'b0;
            s1_angle_q   <= 16'd0;
            s1_product_q <= 32'd0;
        end else if (i_flush) begin
            s1_valid_q   <= 1'b0;
        end else if (adv1_s) begin
            s1_valid_q   <= gnt0_s || gnt1_s;
            s1_id_q      <= gnt1_s;
            s1_clamped_q <= sel_clamped_s;
            s1_angle_q   <= clamped_angle_s;
            s1_product_q <= product_s;
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            o_valid_q      <= 1'b0;
            o_address_q    <= '0;
            o_correction_q <= 4'd0;
            o_id_q         <= 1'b0;
            o_clamped_q    <= 1'b0;
        end else if (i_flush) begin
            o_valid_q      <= 1'b0;
        end else if (adv2_s) begin
            o_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                o_address_q    <= s1_addr_s;
                o_correction_q <= correction_of(s1_angle_q, s1_addr_s);
                o_id_q         <= s1_id_q;
                o_clamped_q    <= s1_clamped_q;
            end
        end
    end

    // Priority and accepted-request counters survive a flush.
    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            prio_q   <= 1'b0;
            count0_q <= 16'd0;
            count1_q <= 16'd0;
        end else begin
            prio_q   <= prio_d;
            count0_q <= count0_d;
            count1_q <= count1_d;
        end
    end

    assign o_req0_ready = gnt0_s;
    assign o_req1_ready = gnt1_s;
    assign o_valid      = o_valid_q;
    assign o_address    = o_address_q;
    assign o_correction = o_correction_q;
    assign o_id         = o_id_q;
    assign o_clamped    = o_clamped_q;
    assign o_count0     = count0_q;
    assign o_count1     = count1_q;

endmodule

// File: tb/tb_memmu_sr_scheduler.sv
// Scoreboard bench for memmu_sr_scheduler: acceptances push hand-computed
// results, a negedge monitor pops and compares on each output handshake.
module tb_memmu_sr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_angle, req1_angle;
    logic        req0_ready, req1_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] address;
    logic [3:0]  correction;
    logic        id;
    logic        clamped;
    logic [15:0] count0, count1;

    always #5 clk = ~clk;

    memmu_sr_scheduler dut (
        .i_SYSTEM_clk (clk),
        .i_SYSTEM_rst (rst_n),
        .i_req0_valid (req0_valid),
        .i_req1_valid (req1_valid),
        .i_req0_angle (req0_angle),
        .i_req1_angle (req1_angle),
        .o_req0_ready (req0_ready),
        .o_req1_ready (req1_ready),
        .i_flush      (flush),
        .o_valid      (out_valid),
        .i_ready      (out_ready),
        .o_address    (address),
        .o_correction (correction),
        .o_id         (id),
        .o_clamped    (clamped),
        .o_count0     (count0),
        .o_count1     (count1)
    );

    typedef struct {
        logic        id;
        logic [10:0] addr;
        logic [3:0]  corr;
        logic        cl;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic prio_m;
    logic g_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Hand-computed results for N=2048, RES=18, FACTOR=113, MAXFOV=35999.
    function automatic exp_t expect_for(input logic [15:0] ang, input logic rid);
        exp_t e;
        e.id = rid;
        case (ang)
            16'd0:     begin e.addr = 11'd0;    e.corr = 4'd0;  e.cl = 1'b0; end
            16'd100:   begin e.addr = 11'd5;    e.corr = 4'd10; e.cl = 1'b0; end
            16'd1800:  begin e.addr = 11'd99;   e.corr = 4'd2;  e.cl = 1'b0; end
            16'd9000:  begin e.addr = 11'd496;  e.corr = 4'd8;  e.cl = 1'b0; end
            16'd18000: begin e.addr = 11'd993;  e.corr = 4'd14; e.cl = 1'b0; end
            16'd27000: begin e.addr = 11'd1489; e.corr = 4'd6;  e.cl = 1'b0; end
            16'd35998: begin e.addr = 11'd1986; e.corr = 4'd10; e.cl = 1'b0; end
            16'd35999: begin e.addr = 11'd1986; e.corr = 4'd11; e.cl = 1'b1; end
            16'd40000: begin e.addr = 11'd1986; e.corr = 4'd11; e.cl = 1'b1; end
            16'd65535: begin e.addr = 11'd1986; e.corr = 4'd11; e.cl = 1'b1; end
            default:   begin e.addr = 11'h7FF;  e.corr = 4'hF;  e.cl = 1'bx; end
        endcase
        return e;
    endfunction

    // Acceptance sampler: checks arbitration against the round-robin model and pushes expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            prio_m = 1'b0;
        end else begin
            if (req0_ready || req1_ready)
                check("ready_exclusive", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (flush) begin
                check("flush_ready", {31'd0, req0_ready | req1_ready}, 32'd0);
                sb_q.delete();
            end else if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) begin
                g_m = (req0_valid && req1_valid) ? prio_m : req1_valid;
                check("arb_grant", {30'd0, req1_ready, req0_ready}, g_m ? 32'd2 : 32'd1);
                sb_q.push_back(expect_for(g_m ? req1_angle : req0_angle, g_m));
                prio_m = !g_m;
            end
        end
    end

    // Output monitor: every delivered result must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            check("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_id", {31'd0, id}, {31'd0, e.id});
                check("out_address", {21'd0, address}, {21'd0, e.addr});
                check("out_correction", {28'd0, correction}, {28'd0, e.corr});
                check("out_clamped", {31'd0, clamped}, {31'd0, e.cl});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic which, input logic [15:0] ang);
        logic ok;
        ok = 1'b0;
        if (which) begin
            req1_valid = 1'b1; req1_angle = ang;
        end else begin
            req0_valid = 1'b1; req0_angle = ang;
        end
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = which ? req1_ready : req0_ready;
            tick();
        end
        check("send_accept", {31'd0, ok}, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb_q.size() > 0; k++) tick();
        check("drain_empty", sb_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_angle = 16'd0; req1_angle = 16'd0; flush = 1'b0; out_ready = 1'b1;
        #22;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_address", {21'd0, address}, 32'd0);
        check("rst_correction", {28'd0, correction}, 32'd0);
        check("rst_id", {31'd0, id}, 32'd0);
        check("rst_clamped", {31'd0, clamped}, 32'd0);
        check("rst_count0", {16'd0, count0}, 32'd0);
        check("rst_count1", {16'd0, count1}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // req0 angle 0: two-cycle latency and count0 = 1
        req0_valid = 1'b1; req0_angle = 16'd0;
        @(negedge clk);
        check("acc_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("lat1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat2_valid", {31'd0, out_valid}, 32'd1);
        check("lat_count0", {16'd0, count0}, 32'd1);
        drain();

        // Single requests across the angle range, including the clamp boundary
        send(1'b1, 16'd1800);
        send(1'b0, 16'd40000);
        send(1'b0, 16'd35998);
        send(1'b1, 16'd35999);
        send(1'b0, 16'd65535);
        send(1'b1, 16'd100);
        send(1'b0, 16'd27000);
        drain();

        // Reset with two results in flight
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_angle = 16'd100;
        req1_valid = 1'b1; req1_angle = 16'd9000;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_count0", {16'd0, count0}, 32'd0);
        check("midrst_count1", {16'd0, count1}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Both requesters held for 6 cycles: ids alternate starting with 0
        req0_valid = 1'b1; req0_angle = 16'd18000;
        req1_valid = 1'b1; req1_angle = 16'd9000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_count0", {16'd0, count0}, 32'd3);
        check("rr_count1", {16'd0, count1}, 32'd3);
        drain();

        // Fill the pipeline with the consumer stalled, then drain
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_angle = 16'd27000;
        req1_valid = 1'b1; req1_angle = 16'd1800;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ready0", {31'd0, req0_ready}, 32'd0);
            check("stall_ready1", {31'd0, req1_ready}, 32'd0);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_address", {21'd0, address}, 32'd1489);
            check("stall_correction", {28'd0, correction}, 32'd6);
            check("stall_id", {31'd0, id}, 32'd0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        check("stall_count0", {16'd0, count0}, 32'd4);
        check("stall_count1", {16'd0, count1}, 32'd4);

        // Flush with two results in flight, overlapping an output handshake
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_angle = 16'd100;
        req1_valid = 1'b1; req1_angle = 16'd18000;
        tick();
        tick();
        req1_valid = 1'b0;
        req0_angle = 16'd9000;
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_count0", {16'd0, count0}, 32'd5);
        check("flush_count1", {16'd0, count1}, 32'd5);
        @(negedge clk);
        check("flush_valid2", {31'd0, out_valid}, 32'd0);
        tick();

        // Recovery after flush
        send(1'b0, 16'd0);
        send(1'b1, 16'd35999);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
